// File: rtl/simon_sequence_engine_if.sv
// Bus between the Simon engine and its surroundings: colour source and
// player inputs in, playback/score/status out.
interface simon_sequence_engine_if #(
    parameter int CW      = 2,
    parameter int MAX_LEN = 32
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN*CW-1:0] colors;
    logic                  start;
    logic                  sel_valid;
    logic [CW-1:0]         sel_color;
    logic                  show_valid;
    logic [CW-1:0]         show_color;
    logic [1:0]            score;
    logic [LW-1:0]         round_len;
    logic                  busy;
    logic                  done;

    modport master (
        output colors, start, sel_valid, sel_color,
        input  show_valid, show_color, score, round_len, busy, done
    );

    modport slave (
        input  colors, start, sel_valid, sel_color,
        output show_valid, show_color, score, round_len, busy, done
    );
endinterface

// File: rtl/simon_sequence_engine.sv
// Simon round engine: latches a colour sequence, plays back the first
// round_len entries, checks the player's presses and grows the round until
// the full sequence is matched (WIN) or a miss/timeout ends it (LOSE).
module simon_sequence_engine #(
    parameter int CW             = 2,
    parameter int MAX_LEN        = 32,
    parameter int START_LEN      = 1,
    parameter int LEN_STEP       = 1,
    parameter int SHOW_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    simon_sequence_engine_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_SHOW, S_INPUT, S_WIN, S_LOSE} state_t;

    state_t                     r_state, w_state_nxt;
    logic [MAX_LEN-1:0][CW-1:0] r_seq, w_seq_nxt;
    logic [LW-1:0]              r_len, w_len_nxt;
    logic [IW-1:0]              r_idx, w_idx_nxt;
    logic [SW-1:0]              r_cnt, w_cnt_nxt;
    logic [TW-1:0]              r_timer, w_timer_nxt;
    logic [1:0]                 r_score, w_score_nxt;
    logic                       r_done, w_done_nxt;
    logic                       r_show_valid, w_show_valid_nxt;
    logic [CW-1:0]              r_show_color, w_show_color_nxt;
    logic                       r_busy, w_busy_nxt;

    logic                       w_last_entry;
    logic                       w_last_cnt;
    logic                       w_timeout;
    logic [CW-1:0]              w_expect;
    logic [31:0]                w_len_sum;
    logic [LW-1:0]              w_len_grow;

    assign w_last_entry = (LW'(r_idx) == r_len - LW'(1));
    assign w_last_cnt   = (r_cnt == SW'(SHOW_CYCLES - 1));
    assign w_timeout    = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_expect     = r_seq[r_idx];
    // Next round length saturates at the sequence depth.
    assign w_len_sum    = 32'(r_len) + 32'(LEN_STEP);
    assign w_len_grow   = (w_len_sum > 32'(MAX_LEN)) ? LW'(MAX_LEN) : w_len_sum[LW-1:0];

    // Next-state and next-datapath decisions; start overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_seq_nxt   = r_seq;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_score_nxt = r_score;
        w_done_nxt  = r_done;
        if (bus.start) begin
            w_state_nxt = S_SHOW;
            w_seq_nxt   = bus.colors;
            w_len_nxt   = LW'(START_LEN);
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_timer_nxt = '0;
            w_score_nxt = 2'b00;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_SHOW: begin
                    if (w_last_cnt) begin
                        w_cnt_nxt = '0;
                        if (w_last_entry) begin
                            w_state_nxt = S_INPUT;
                            w_idx_nxt   = '0;
                            w_timer_nxt = '0;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + SW'(1);
                    end
                end
                S_INPUT: begin
                    // A press in the final idle cycle beats the timeout.
                    if (bus.sel_valid) begin
                        w_timer_nxt = '0;
                        if (bus.sel_color == w_expect) begin
                            w_score_nxt = 2'b01;
                            if (!w_last_entry) begin
                                w_idx_nxt = r_idx + IW'(1);
                            end else if (r_len == LW'(MAX_LEN)) begin
                                w_state_nxt = S_WIN;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_len_nxt   = w_len_grow;
                                w_idx_nxt   = '0;
                                w_cnt_nxt   = '0;
                                w_state_nxt = S_SHOW;
                            end
                        end else begin
                            w_score_nxt = 2'b10;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_LOSE;
                        end
                    end else if (w_timeout) begin
                        w_score_nxt = 2'b11;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_LOSE;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                default: ;
            endcase
        end
        // Outputs are registered from the next state so playback starts
        // the cycle right after start or a completed round.
        w_show_valid_nxt = (w_state_nxt == S_SHOW);
        w_show_color_nxt = w_show_valid_nxt ? w_seq_nxt[w_idx_nxt] : '0;
        w_busy_nxt       = (w_state_nxt == S_SHOW) || (w_state_nxt == S_INPUT);
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_seq        <= '0;
            r_len        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_timer      <= '0;
            r_score      <= 2'b00;
            r_done       <= 1'b0;
            r_show_valid <= 1'b0;
            r_show_color <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_seq        <= w_seq_nxt;
            r_len        <= w_len_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_timer      <= w_timer_nxt;
            r_score      <= w_score_nxt;
            r_done       <= w_done_nxt;
            r_show_valid <= w_show_valid_nxt;
            r_show_color <= w_show_color_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign bus.show_valid = r_show_valid;
    assign bus.show_color = r_show_color;
    assign bus.score      = r_score;
    assign bus.round_len  = r_len;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_simon_sequence_engine.sv
// Bench: two engines (default and a short clamped game) checked every
// negedge against a game-rule model, plus directed literal expectations.
module tb_simon_sequence_engine;
    localparam int SC = 4;
    localparam int TO = 8;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    simon_sequence_engine_if #(.CW(2), .MAX_LEN(32)) if_a ();
    simon_sequence_engine_if #(.CW(2), .MAX_LEN(4))  if_b ();

    simon_sequence_engine #(
        .CW(2), .MAX_LEN(32), .START_LEN(1), .LEN_STEP(1),
        .SHOW_CYCLES(SC), .TIMEOUT_CYCLES(TO)
    ) dut_a (.i_clk(clk), .i_reset(rst), .bus(if_a));

    simon_sequence_engine #(
        .CW(2), .MAX_LEN(4), .START_LEN(3), .LEN_STEP(2),
        .SHOW_CYCLES(SC), .TIMEOUT_CYCLES(TO)
    ) dut_b (.i_clk(clk), .i_reset(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game-level model: t = cycles into playback, pos = next entry the
    // player owes, idle = silent cycles while waiting for the player.
    typedef struct packed {
        logic [63:0] seq;
        int          len;
        bit          showing;
        bit          inputting;
        int          t;
        int          pos;
        int          idle;
        logic [1:0]  score;
        bit          over;
    } model_t;

    model_t m_a = '0;
    model_t m_b = '0;

    function automatic logic [1:0] entry(logic [63:0] seq, int i);
        return seq[2*i +: 2];
    endfunction

    function automatic model_t mstep(model_t m, int max_len, int start_len, int step,
                                     logic start, logic [63:0] colors,
                                     logic sv, logic [1:0] sc);
        model_t n = m;
        if (start) begin
            n = '0;
            n.seq     = colors;
            n.len     = start_len;
            n.showing = 1'b1;
            return n;
        end
        if (m.showing) begin
            n.t = m.t + 1;
            if (n.t == m.len * SC) begin
                n.showing   = 1'b0;
                n.inputting = 1'b1;
                n.pos       = 0;
                n.idle      = 0;
            end
        end else if (m.inputting) begin
            if (sv) begin
                n.idle = 0;
                if (sc == entry(m.seq, m.pos)) begin
                    n.score = 2'b01;
                    n.pos   = m.pos + 1;
                    if (n.pos == m.len) begin
                        n.inputting = 1'b0;
                        if (m.len == max_len) begin
                            n.over = 1'b1;
                        end else begin
                            n.len     = (m.len + step > max_len) ? max_len : m.len + step;
                            n.showing = 1'b1;
                            n.t       = 0;
                        end
                    end
                end else begin
                    n.score     = 2'b10;
                    n.over      = 1'b1;
                    n.inputting = 1'b0;
                end
            end else begin
                n.idle = m.idle + 1;
                if (n.idle == TO) begin
                    n.score     = 2'b11;
                    n.over      = 1'b1;
                    n.inputting = 1'b0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= '0;
            m_b <= '0;
        end else begin
            m_a <= mstep(m_a, 32, 1, 1, if_a.start, if_a.colors, if_a.sel_valid, if_a.sel_color);
            m_b <= mstep(m_b, 4, 3, 2, if_b.start, 64'(if_b.colors), if_b.sel_valid, if_b.sel_color);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(string tag, model_t m, logic sv, logic [1:0] sc, logic [1:0] score,
                       logic [5:0] len, logic busy, logic done);
        logic [1:0] exp_col;
        exp_col = m.showing ? entry(m.seq, m.t / SC) : 2'b00;
        chk({tag, ".show_valid"}, 32'(sv), 32'(m.showing));
        chk({tag, ".show_color"}, 32'(sc), 32'(exp_col));
        chk({tag, ".score"}, 32'(score), 32'(m.score));
        chk({tag, ".round_len"}, 32'(len), m.len);
        chk({tag, ".busy"}, 32'(busy), 32'(m.showing | m.inputting));
        chk({tag, ".done"}, 32'(done), 32'(m.over));
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            cmp("A", m_a, if_a.show_valid, if_a.show_color, if_a.score,
                6'(if_a.round_len), if_a.busy, if_a.done);
            cmp("B", m_b, if_b.show_valid, if_b.show_color, if_b.score,
                6'(if_b.round_len), if_b.busy, if_b.done);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_a(logic [63:0] c);
        if_a.colors = c;
        if_a.start  = 1'b1;
        tick();
        if_a.start  = 1'b0;
    endtask

    task automatic press_a(logic [1:0] c);
        if_a.sel_valid = 1'b1;
        if_a.sel_color = c;
        tick();
        if_a.sel_valid = 1'b0;
    endtask

    task automatic press_b(logic [1:0] c);
        if_b.sel_valid = 1'b1;
        if_b.sel_color = c;
        tick();
        if_b.sel_valid = 1'b0;
    endtask

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        rst = 1'b1;
        if_a.colors = '0; if_a.start = 0; if_a.sel_valid = 0; if_a.sel_color = 0;
        if_b.colors = '0; if_b.start = 0; if_b.sel_valid = 0; if_b.sel_color = 0;
        tick(2);
        rst = 1'b0;
        chk("reset.score", 32'(if_a.score), 0);
        chk("reset.round_len", 32'(if_a.round_len), 0);

        // Reset mid-SHOW aborts; presses afterwards are ignored.
        start_a(64'h6);
        tick(2);
        rst = 1'b1;
        #1;
        chk("midrst.show_valid", 32'(if_a.show_valid), 0);
        chk("midrst.round_len", 32'(if_a.round_len), 0);
        chk("midrst.busy", 32'(if_a.busy), 0);
        tick();
        rst = 1'b0;
        press_a(2'd2);
        press_a(2'd1);
        chk("idle_press.score", 32'(if_a.score), 0);
        chk("idle_press.busy", 32'(if_a.busy), 0);

        // Round 1: entry0=2 shown for 4 cycles, correct press grows round.
        start_a(64'h6);
        chk("r1.show_color", 32'(if_a.show_color), 2);
        chk("r1.round_len", 32'(if_a.round_len), 1);
        tick(3);
        chk("r1.still_show", 32'(if_a.show_valid), 1);
        tick();
        chk("r1.input_noshow", 32'(if_a.show_valid), 0);
        chk("r1.input_busy", 32'(if_a.busy), 1);
        press_a(2'd2);
        chk("r1.score", 32'(if_a.score), 1);
        chk("r2.round_len", 32'(if_a.round_len), 2);
        chk("r2.first_color", 32'(if_a.show_color), 2);
        tick(4);
        chk("r2.second_color", 32'(if_a.show_color), 1);
        tick(4);

        // Round 2: wrong second press loses; later presses ignored.
        press_a(2'd2);
        press_a(2'd3);
        chk("wrong.score", 32'(if_a.score), 2);
        chk("wrong.done", 32'(if_a.done), 1);
        chk("wrong.round_len", 32'(if_a.round_len), 2);
        press_a(2'd1);
        chk("lose_press.score", 32'(if_a.score), 2);

        // Timeout after 8 silent cycles.
        start_a(64'h6);
        tick(4);
        tick(7);
        chk("to7.score", 32'(if_a.score), 0);
        chk("to7.busy", 32'(if_a.busy), 1);
        tick();
        chk("to8.score", 32'(if_a.score), 3);
        chk("to8.done", 32'(if_a.done), 1);

        // Press on the 8th cycle beats the timeout.
        start_a(64'h6);
        tick(4);
        tick(7);
        press_a(2'd2);
        chk("late_press.score", 32'(if_a.score), 1);
        chk("late_press.done", 32'(if_a.done), 0);
        chk("late_press.round_len", 32'(if_a.round_len), 2);

        // Restart during INPUT, with a coincident press: start wins.
        tick(8);
        chk("pre_restart.busy", 32'(if_a.busy), 1);
        if_a.sel_valid = 1'b1;
        if_a.sel_color = 2'd1;
        start_a(64'h3);
        if_a.sel_valid = 1'b0;
        chk("restart.round_len", 32'(if_a.round_len), 1);
        chk("restart.score", 32'(if_a.score), 0);
        chk("restart.show_color", 32'(if_a.show_color), 3);
        tick(6);

        // Short game: 3 -> 4 (clamped) -> WIN.
        if_b.colors = 8'h39;
        if_b.start  = 1'b1;
        tick();
        if_b.start  = 1'b0;
        chk("b.start_len", 32'(if_b.round_len), 3);
        tick(12);
        press_b(2'd1);
        press_b(2'd2);
        press_b(2'd3);
        chk("b.clamped_len", 32'(if_b.round_len), 4);
        chk("b.r1_score", 32'(if_b.score), 1);
        chk("b.r2_show", 32'(if_b.show_color), 1);
        tick(16);
        press_b(2'd1);
        press_b(2'd2);
        press_b(2'd3);
        press_b(2'd0);
        chk("b.win_done", 32'(if_b.done), 1);
        chk("b.win_score", 32'(if_b.score), 1);
        chk("b.win_busy", 32'(if_b.busy), 0);
        chk("b.win_len", 32'(if_b.round_len), 4);
        press_b(2'd2);
        chk("b.win_hold", 32'(if_b.score), 1);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
